apb_mem_responder: RTL and testbench

//  APB3 completer (responder) fronting a word-addressed scratch memory.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_sp_ram.sv | 36 +++
 rtl/apb_mem_responder.sv | 145 ++++++++++++++
 tb/tb_apb_mem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions for the completer and requester blocks.
//   apb_state_e   : bus phase as seen by a completer (IDLE, SETUP, ACCESS)
//   DATA_W        : APB data width
//   APB_ADDR_LSB  : number of byte-offset bits below the word index
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DATA_W       = 32;
  localparam int APB_ADDR_LSB = 2;

endpackage

// File: rtl/apb_sp_ram.sv
// Single-port DEPTH x DATA_W scratch memory.
// Synchronous write, combinational read, synchronous clear of every word.
// Ports:
//   clk    clock
//   reset  synchronous active-high clear of all words
//   we     write enable (one word at idx)
//   idx    word index shared by read and write
//   wdata  write data
//   rdata  combinational read data at idx
module apb_sp_ram
  import apb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/apb_mem_responder.sv
// APB3 completer in front of a word-addressed scratch memory.
// Adds WAIT_CYCLES wait states per transfer and flags misaligned or
// out-of-range addresses with pslverr_o. All outputs are registered.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   psel_i, penable_i     APB select / access-phase enable
//   pwrite_i              1 = write, 0 = read
//   paddr_i               byte address
//   pwdata_i              write data
//   pready_o              transfer completes in the cycle it is high
//   prdata_o              read data (valid with pready_o on a read)
//   pslverr_o             error flag (valid with pready_o)
module apb_mem_responder
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic              pready_o,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pslverr_o
);

  localparam int AW = $clog2(DEPTH);

  apb_state_e        state_q, state_d, phase;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              pready_d, pslverr_d;
  logic [DATA_W-1:0] prdata_d;
  logic              fin;

  logic [ADDR_W-1:0] acc_addr;
  logic              acc_wr, acc_err;
  logic [AW-1:0]     ram_idx;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[APB_ADDR_LSB-1:0] != '0) ||
           (32'(a[ADDR_W-1:APB_ADDR_LSB]) >= 32'(DEPTH));
  endfunction

  apb_sp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The state register only ever holds IDLE or ACCESS; the SETUP phase is
  // the cycle in which IDLE sees psel_i & !penable_i, so that with zero wait
  // states the registered pready_o can rise in the first ACCESS cycle.
  always_comb begin
    phase = IDLE;
    if (state_q == ACCESS)           phase = ACCESS;
    else if (psel_i && !penable_i)   phase = SETUP;

    // Decode works on the live bus in SETUP and on the latched copy after.
    acc_addr = (phase == SETUP) ? paddr_i  : addr_q;
    acc_wr   = (phase == SETUP) ? pwrite_i : wr_q;
    acc_err  = addr_err(acc_addr);
    ram_idx  = acc_addr[APB_ADDR_LSB +: AW];

    state_d   = IDLE;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    fin       = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    case (phase)
      SETUP: begin
        state_d = ACCESS;
        wr_d    = pwrite_i;
        addr_d  = paddr_i;
        wdata_d = pwdata_i;
        cnt_d   = 4'(WAIT_CYCLES);
        fin     = (WAIT_CYCLES == 0);
      end
      ACCESS: begin
        if (pready_o) begin
          state_d = IDLE;
        end else if (!psel_i) begin
          // Requester abandoned the transfer: no pready pulse, no write.
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
          cnt_d   = cnt_q - 4'd1;
          fin     = (cnt_q == 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    // fin means the next cycle is the completing one.
    if (fin) begin
      pready_d  = 1'b1;
      pslverr_d = acc_err;
      prdata_d  = (!acc_wr && !acc_err) ? ram_rdata : '0;
    end

    ram_we = (state_q == ACCESS) && pready_o && psel_i && wr_q && !acc_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      pready_o  <= pready_d;
      pslverr_o <= pslverr_d;
      prdata_o  <= prdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
module tb_apb_mem_responder;

  logic        clk;
  logic        rst     [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [9:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];

  int waits [2] = '{1, 0};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] ref_mem [2][64];

  apb_mem_responder #(.DEPTH(64), .WAIT_CYCLES(1), .ADDR_W(10)) u_dut0 (
    .clk(clk), .reset(rst[0]), .psel_i(psel[0]), .penable_i(penable[0]),
    .pwrite_i(pwrite[0]), .paddr_i(paddr[0]), .pwdata_i(pwdata[0]),
    .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0])
  );

  apb_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .ADDR_W(10)) u_dut1 (
    .clk(clk), .reset(rst[1]), .psel_i(psel[1]), .penable_i(penable[1]),
    .pwrite_i(pwrite[1]), .paddr_i(paddr[1]), .pwdata_i(pwdata[1]),
    .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, act, exp);
    end
  endtask

  task automatic clear_ref(input int d);
    for (int i = 0; i < 64; i++) ref_mem[d][i] = 32'h0;
  endtask

  // One full transfer; the next call starts in the cycle after pready,
  // giving back-to-back traffic with no idle cycle.
  task automatic xfer(input int d, input logic wr, input logic [9:0] addr,
                      input logic [31:0] wd);
    exp_t e;
    int   cyc;
    @(posedge clk); #1;
    chk("rdy_low_before", {31'b0, pready[d]}, 32'h0);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wd;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wd;
    e.err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= 10'd64);
    e.rdata = (wr || e.err) ? 32'h0 : ref_mem[d][addr[7:2]];
    sb_q.push_back(e);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    // Bus changes during ACCESS must be ignored.
    paddr[d]  = ~addr;
    pwdata[d] = ~wd;
    cyc = 0;
    while (pready[d] !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20) begin
      chk("pready_timeout", 32'(cyc), 32'h0);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk("access_cycles", 32'(cyc + 1), 32'(waits[d] + 1));
      chk("pslverr", {31'b0, pslverr[d]}, {31'b0, e.err});
      if (!e.wr || e.err) chk("prdata", prdata[d], e.rdata);
      if (e.wr && !e.err) ref_mem[d][e.addr[7:2]] = e.wdata;
    end
  endtask

  task automatic bus_idle(input int d);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("rdy_low_after", {31'b0, pready[d]}, 32'h0);
    chk("err_low_after", {31'b0, pslverr[d]}, 32'h0);
    chk("rdata_low_after", prdata[d], 32'h0);
  endtask

  task automatic run_all(input int d);
    logic [9:0] a;
    // Read right after reset
    xfer(d, 1'b0, 10'h004, 32'h0);
    bus_idle(d);
    // Write then read back
    xfer(d, 1'b1, 10'h010, 32'hDEADBEEF);
    bus_idle(d);
    xfer(d, 1'b0, 10'h010, 32'h0);
    chk("readback_value", prdata[d], 32'hDEADBEEF);
    bus_idle(d);
    // Out-of-range write, misaligned read, word 0 untouched
    xfer(d, 1'b1, 10'h100, 32'h12345678);
    xfer(d, 1'b0, 10'h002, 32'h0);
    xfer(d, 1'b0, 10'h000, 32'h0);
    chk("word0_untouched", prdata[d], 32'h0);
    bus_idle(d);
    // Back-to-back write/read
    xfer(d, 1'b1, 10'h008, 32'h1);
    xfer(d, 1'b0, 10'h008, 32'h0);
    chk("b2b_value", prdata[d], 32'h1);
    bus_idle(d);
    // psel dropped in the first ACCESS cycle
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
    paddr[d] = 10'h00C; pwdata[d] = 32'hAA;
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b1;
    if (waits[d] > 0) chk("abort_rdy_access", {31'b0, pready[d]}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      penable[d] = 1'b0;
      chk("abort_rdy_after", {31'b0, pready[d]}, 32'h0);
    end
    xfer(d, 1'b0, 10'h00C, 32'h0);
    chk("abort_no_write", prdata[d], 32'h0);
    bus_idle(d);
    // Reset during the ACCESS of a write
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
    paddr[d] = 10'h014; pwdata[d] = 32'h55;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    rst[d] = 1'b1;
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("midrst_rdy", {31'b0, pready[d]}, 32'h0);
    chk("midrst_err", {31'b0, pslverr[d]}, 32'h0);
    chk("midrst_rdata", prdata[d], 32'h0);
    rst[d] = 1'b0;
    clear_ref(d);
    xfer(d, 1'b0, 10'h014, 32'h0);
    chk("midrst_no_write", prdata[d], 32'h0);
    xfer(d, 1'b0, 10'h010, 32'h0);
    chk("midrst_mem_cleared", prdata[d], 32'h0);
    bus_idle(d);
    // Random legal traffic against the reference array
    for (int n = 0; n < 512; n++) begin
      a = {2'b00, 6'($urandom_range(0, 63)), 2'b00};
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) bus_idle(d);
    end
    bus_idle(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0;
      clear_ref(d);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_rdy", {31'b0, pready[d]}, 32'h0);
      chk("reset_err", {31'b0, pslverr[d]}, 32'h0);
      chk("reset_rdata", prdata[d], 32'h0);
      rst[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) run_all(d);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
